// File: rtl/axi_pkg.sv
// Shared AXI responder definitions: burst/response encodings, responder FSM state type
// and the per-beat address step helper.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} resp_state_t;

  // Next beat address. Reserved burst codes behave as INCR; INCR wraps mod 2^32.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
    if (burst == BURST_INCR || burst[1]) begin
      return addr + (32'd1 << size);
    end
    return addr;
  endfunction

endpackage

// File: rtl/axi_ram_bank.sv
// Word-wide RAM behind the AXI responder.
// Ports: clk; addr word index; we write enable; be byte enables; wdata write word;
//        rdata combinational read of the word at addr.
// Contents are never reset.
module axi_ram_bank
  import axi_pkg::*;
#(
  parameter int unsigned AW_WORDS = 12
) (
  input  logic                clk,
  input  logic [AW_WORDS-1:0] addr,
  input  logic                we,
  input  logic [3:0]          be,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  localparam int unsigned Depth = 1 << AW_WORDS;

  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/axi_ram_responder.sv
// AXI memory responder: one read or write transaction at a time, single beat or
// INCR/FIXED burst, backed by axi_ram_bank.
// Ports: clk, rst (async, active high); AR/R, AW/W/B channel signals of an AXI slave.
//        lock/cache/prot and wid are accepted but ignored.
// Optional build macro AXI_RESP_WAIT_EN: inserts WAIT_CYCLES wait states before each
// rvalid / wready / bvalid assertion via a down-counter reloaded on every handshake.
module axi_ram_responder
  import axi_pkg::*;
#(
  parameter int unsigned AW_WORDS    = 12,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic            awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  resp_state_t     state_q;
  logic [31:0]     addr_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic [ID_W-1:0] id_q;
  logic            err_q;
  logic [31:0]     ram_rdata;

  logic ar_hs, aw_hs, r_hs, w_hs, b_hs, last, ram_we, wlast_bad;
  logic wait_r_ok, wait_wb_ok;

  // Ready is combinational so the IDLE accept decision sees the current valids;
  // gated by rst so nothing is accepted while reset is held.
  assign awready = ~rst & (state_q == IDLE) & awvalid;
  assign arready = ~rst & (state_q == IDLE) & ~awvalid;

  assign ar_hs     = arvalid & arready;
  assign aw_hs     = awvalid & awready;
  assign r_hs      = rvalid & rready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;
  assign last      = (cnt_q == len_q);
  assign wlast_bad = wlast ^ last;
  assign ram_we    = (state_q == WR) & w_hs;

`ifdef AXI_RESP_WAIT_EN
  localparam logic NoWait = (WAIT_CYCLES == 0);
  logic [7:0] wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (ar_hs | aw_hs | r_hs | w_hs | b_hs) begin
      wait_q <= 8'(WAIT_CYCLES);
    end else if (wait_q != 8'd0) begin
      wait_q <= wait_q - 8'd1;
    end
  end

  // rvalid is registered one cycle after its trigger; wready/bvalid are armed on the
  // handshake edge itself, so they may rise one count earlier to get the same delay.
  assign wait_r_ok  = (wait_q == 8'd0);
  assign wait_wb_ok = (wait_q <= 8'd1);
`else
  localparam logic NoWait = 1'b1;
  logic [31:0] unused_wait;
  assign unused_wait = WAIT_CYCLES;
  assign wait_r_ok   = 1'b1;
  assign wait_wb_ok  = 1'b1;
`endif

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_hs) begin
            state_q <= WR;
            addr_q  <= awaddr;
            len_q   <= {4'b0000, awlen};
            size_q  <= awsize;
            burst_q <= awburst;
            id_q    <= awid;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wready  <= NoWait;
          end else if (ar_hs) begin
            state_q <= RD;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            id_q    <= arid;
            cnt_q   <= '0;
          end
        end
        RD: begin
          if (!rvalid) begin
            if (wait_r_ok) begin
              rvalid <= 1'b1;
              rdata  <= ram_rdata;
              rid    <= id_q;
              rresp  <= RESP_OKAY;
              rlast  <= last;
            end
          end else if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (last) begin
              state_q <= IDLE;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= axi_next_addr(addr_q, size_q, burst_q);
            end
          end
        end
        WR: begin
          if (w_hs) begin
            err_q <= err_q | wlast_bad;
            if (last) begin
              state_q <= WRESP;
              wready  <= 1'b0;
              bvalid  <= NoWait;
              bid     <= id_q;
              bresp   <= (err_q | wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= axi_next_addr(addr_q, size_q, burst_q);
              wready <= NoWait;
            end
          end else if (!wready && wait_wb_ok) begin
            wready <= 1'b1;
          end
        end
        WRESP: begin
          if (bvalid) begin
            if (bready) begin
              bvalid  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (wait_wb_ok) begin
            bvalid <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  axi_ram_bank #(
    .AW_WORDS(AW_WORDS)
  ) u_bank (
    .clk  (clk),
    .addr (addr_q[AW_WORDS+1:2]),
    .we   (ram_we),
    .be   (wstrb),
    .wdata(wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed self-checking bench for axi_ram_responder (default build, no wait states).
// Inputs change on the falling edge; outputs are sampled just after the falling edge.
module tb_axi_ram_responder;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [7:0]  arlen = '0;
  logic [3:0]  awlen = '0, wstrb = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2;
  logic [1:0]  arburst = BURST_INCR, awburst = BURST_INCR, rresp, bresp;
  logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic        arready, awready, wready, rvalid, rlast, bvalid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_ram_responder dut (
    .clk    (clk),
    .rst    (rst),
    .arid   (arid),
    .araddr (araddr),
    .arlen  (arlen),
    .arsize (arsize),
    .arburst(arburst),
    .arlock (1'b0),
    .arcache(4'h0),
    .arprot (3'h0),
    .arvalid(arvalid),
    .arready(arready),
    .rid    (rid),
    .rdata  (rdata),
    .rresp  (rresp),
    .rlast  (rlast),
    .rvalid (rvalid),
    .rready (rready),
    .awid   (awid),
    .awaddr (awaddr),
    .awlen  (awlen),
    .awsize (awsize),
    .awburst(awburst),
    .awlock (1'b0),
    .awcache(4'h0),
    .awprot (3'h0),
    .awvalid(awvalid),
    .awready(awready),
    .wid    (wid),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wlast  (wlast),
    .wvalid (wvalid),
    .wready (wready),
    .bid    (bid),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic aw_xfer(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (awready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("aw_handshake", ok, 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic ar_xfer(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (arready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("ar_handshake", ok, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    logic ok;
    ok = 1'b0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (wready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("w_handshake", ok, 1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait(input logic [3:0] id, input logic [1:0] resp);
    logic ok;
    ok = 1'b0;
    bready = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (bvalid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("b_valid", ok, 1);
    chk("bid", bid, id);
    chk("bresp", bresp, resp);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic r_beat(input logic [31:0] data, input logic last, input logic [3:0] id);
    logic ok;
    ok = 1'b0;
    rready = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (rvalid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("r_valid", ok, 1);
    chk("rdata", rdata, data);
    chk("rlast", rlast, last);
    chk("rid", rid, id);
    chk("rresp", rresp, RESP_OKAY);
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] data);
    aw_xfer(4'd1, addr, 4'd0, BURST_INCR);
    w_beat(data, 4'hF, 1'b1);
    b_wait(4'd1, RESP_OKAY);
  endtask

  initial begin
    logic ok;
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("idle_arready", arready, 1);

    // Single read, including the one-cycle rvalid latency
    write1(32'h40, 32'hDEADBEEF);
    ar_xfer(4'd3, 32'h40, 8'd0, 3'd2, BURST_INCR);
    #1 chk("rd_latency_early", rvalid, 0);
    @(negedge clk); #1 chk("rd_latency_valid", rvalid, 1);
    r_beat(32'hDEADBEEF, 1'b1, 4'd3);

    // Strobed write over a zeroed word
    write1(32'h44, 32'h0);
    aw_xfer(4'd5, 32'h44, 4'd0, BURST_INCR);
    w_beat(32'h11223344, 4'b0101, 1'b1);
    b_wait(4'd5, RESP_OKAY);
    ar_xfer(4'd0, 32'h44, 8'd0, 3'd2, BURST_INCR);
    r_beat(32'h00220044, 1'b1, 4'd0);

    // INCR burst, read back with rready toggling; data must hold while stalled
    aw_xfer(4'd2, 32'h100, 4'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) w_beat(32'hC0DE0000 + i, 4'hF, i == 3);
    b_wait(4'd2, RESP_OKAY);
    ar_xfer(4'd4, 32'h100, 8'd3, 3'd2, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (rvalid) begin ok = 1'b1; break; end
        @(negedge clk); #1;
      end
      chk("burst_valid", ok, 1);
      @(negedge clk); #1;
      chk("burst_hold_valid", rvalid, 1);
      chk("burst_hold_data", rdata, 32'hC0DE0000 + i);
      r_beat(32'hC0DE0000 + i, i == 3, 4'd4);
    end

    // Narrow INCR read: 1-byte steps stay within word 0x104
    ar_xfer(4'd6, 32'h104, 8'd3, 3'd0, BURST_INCR);
    for (int i = 0; i < 4; i++) r_beat(32'hC0DE0001, i == 3, 4'd6);

    // Address wrap mod 2^32 and upper-bit aliasing
    write1(32'h0000FFFC, 32'hAAAA5555);
    write1(32'h00000000, 32'h12345678);
    ar_xfer(4'd8, 32'hFFFFFFFC, 8'd1, 3'd2, BURST_INCR);
    r_beat(32'hAAAA5555, 1'b0, 4'd8);
    r_beat(32'h12345678, 1'b1, 4'd8);

    // FIXED burst: both beats hit the same word
    aw_xfer(4'd3, 32'h300, 4'd1, BURST_FIXED);
    w_beat(32'h11111111, 4'hF, 1'b0);
    w_beat(32'h22222222, 4'hF, 1'b1);
    b_wait(4'd3, RESP_OKAY);
    ar_xfer(4'd3, 32'h300, 8'd1, 3'd2, BURST_FIXED);
    r_beat(32'h22222222, 1'b0, 4'd3);
    r_beat(32'h22222222, 1'b1, 4'd3);

    // Tie: write wins, read accepted after the B handshake
    awid = 4'd9; awaddr = 32'h400; awlen = 4'd0; awburst = BURST_INCR; awvalid = 1'b1;
    arid = 4'd10; araddr = 32'h400; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
    arvalid = 1'b1;
    #1;
    chk("tie_awready", awready, 1);
    chk("tie_arready", arready, 0);
    @(negedge clk);
    awvalid = 1'b0;
    #1 chk("tie_arready_wr", arready, 0);
    w_beat(32'h5A5A5A5A, 4'hF, 1'b1);
    b_wait(4'd9, RESP_OKAY);
    ar_xfer(4'd10, 32'h400, 8'd0, 3'd2, BURST_INCR);
    r_beat(32'h5A5A5A5A, 1'b1, 4'd10);

    // Protocol error: early wlast, both beats still written
    aw_xfer(4'd7, 32'h200, 4'd1, BURST_INCR);
    w_beat(32'h000000E0, 4'hF, 1'b1);
    w_beat(32'h000000E1, 4'hF, 1'b1);
    b_wait(4'd7, RESP_SLVERR);
    ar_xfer(4'd7, 32'h200, 8'd1, 3'd2, BURST_INCR);
    r_beat(32'h000000E0, 1'b0, 4'd7);
    r_beat(32'h000000E1, 1'b1, 4'd7);

    // Reset during the second beat of a read burst
    ar_xfer(4'd1, 32'h100, 8'd3, 3'd2, BURST_INCR);
    r_beat(32'hC0DE0000, 1'b0, 4'd1);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rvalid) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("rst_mid_valid_before", ok, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_rlast", rlast, 0);
    arid = 4'd2; araddr = 32'h40; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
    arvalid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    r_beat(32'hDEADBEEF, 1'b1, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
